// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } arb_state_t;

    localparam int BYTE_W = 8;

    // Grant index width; a single requester bit still needs one bit of index.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping past NUM_REQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on pick_vld.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDXW    = idx_w(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic               pick_vld,
    output logic [IDXW-1:0]    pick_idx
);

    int cand;

    // Walk the request vector starting at ptr; the modulo keeps every candidate below NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one 8N1 UART transmitter among NUM_REQ byte producers; optional watchdog via UART_ARB_TIMEOUT_EN.
// Latency: request to Ack/TX_DV 1 clock; TX_Done to Req_Done 1 clock; GAP_CLKS idle clocks before the next grant.
// Backpressure: requests are held until acked; no grant while the transmitter is active or a frame/gap is in progress.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  GAP_CLKS     = 0,
    parameter int  TIMEOUT_CLKS = 4096,
    localparam int IDXW         = idx_w(NUM_REQ)
)(
    input  logic                      i_Clock,
    input  logic                      i_Rst,
    input  logic [NUM_REQ-1:0]        i_Req_DV,
    input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]        o_Req_Ack,
    output logic [NUM_REQ-1:0]        o_Req_Done,
    output logic                      o_TX_DV,
    output logic [BYTE_W-1:0]         o_TX_Byte,
    input  logic                      i_TX_Active,
    input  logic                      i_TX_Done,
    output logic [IDXW-1:0]           o_Grant,
    output logic                      o_Busy,
    output logic                      o_Timeout
);

    localparam int              GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CLKS - 1);

    arb_state_t           state_q, state_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic [IDXW-1:0]      grant_d;
    logic [BYTE_W-1:0]    byte_d;
    logic [NUM_REQ-1:0]   ack_d, done_d;
    logic                 dv_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 pick_vld;
    logic [IDXW-1:0]      pick_idx;
    logic                 frame_end;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (i_Req_DV),
        .ptr      (ptr_q),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    logic [WW-1:0] wd_q, wd_d;
    logic          wd_expire;
    logic          to_d;

    assign wd_expire = (wd_q == WW'(TIMEOUT_CLKS - 1));
    assign frame_end = i_TX_Done || wd_expire;

    // Watchdog counts only while a frame is outstanding; a real Done wins over a same-cycle expiry.
    always_comb begin
        wd_d = '0;
        to_d = 1'b0;
        if (state_q == WAIT_DONE) begin
            wd_d = wd_q + 1'b1;
            to_d = wd_expire && !i_TX_Done;
        end
    end

    // Watchdog counter and one-cycle abort pulse.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            wd_q      <= '0;
            o_Timeout <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            o_Timeout <= to_d;
        end
    end
`else
    assign frame_end = i_TX_Done;
    assign o_Timeout = 1'b0;
`endif

    assign o_Busy = (state_q != IDLE);

    // Next-state and next-output logic; strobes default low so they last a single cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = o_Grant;
        byte_d  = o_TX_Byte;
        ack_d   = '0;
        done_d  = '0;
        dv_d    = 1'b0;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (pick_vld && !i_TX_Active) begin
                    ack_d[pick_idx] = 1'b1;
                    dv_d            = 1'b1;
                    byte_d          = i_Req_Byte[pick_idx*BYTE_W +: BYTE_W];
                    grant_d         = pick_idx;
                    ptr_d           = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                    state_d         = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (frame_end) begin
                    done_d[o_Grant] = 1'b1;
                    gap_d           = '0;
                    state_d         = (GAP_CLKS > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and registered outputs; reset abandons any frame without reporting Done.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gap_q      <= '0;
            o_Grant    <= '0;
            o_TX_Byte  <= '0;
            o_TX_DV    <= 1'b0;
            o_Req_Ack  <= '0;
            o_Req_Done <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gap_q      <= gap_d;
            o_Grant    <= grant_d;
            o_TX_Byte  <= byte_d;
            o_TX_DV    <= dv_d;
            o_Req_Ack  <= ack_d;
            o_Req_Done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: time-based reference model plus directed scenarios.
// Latency: model predicts every output for every clock.
// Backpressure: a simple transmitter responder drives Active/Done from TX_DV.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 5;
    localparam int TMO  = 100;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              i_Clock = 1'b0;
    logic              i_Rst   = 1'b0;
    logic [NREQ-1:0]   i_Req_DV = '0;
    logic [8*NREQ-1:0] i_Req_Byte = {8'h44, 8'hA5, 8'h22, 8'h11};
    logic [NREQ-1:0]   o_Req_Ack, o_Req_Done;
    logic              o_TX_DV;
    logic [7:0]        o_TX_Byte;
    logic              i_TX_Active;
    logic              i_TX_Done = 1'b0;
    logic [1:0]        o_Grant;
    logic              o_Busy, o_Timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .GAP_CLKS     (GAP),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Rst       (i_Rst),
        .i_Req_DV    (i_Req_DV),
        .i_Req_Byte  (i_Req_Byte),
        .o_Req_Ack   (o_Req_Ack),
        .o_Req_Done  (o_Req_Done),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (i_TX_Active),
        .i_TX_Done   (i_TX_Done),
        .o_Grant     (o_Grant),
        .o_Busy      (o_Busy),
        .o_Timeout   (o_Timeout)
    );

    always #5 i_Clock = ~i_Clock;

    int n_checks = 0;
    int n_err    = 0;
    int tb_cyc   = 0;

    always @(posedge i_Clock) tb_cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, tb_cyc);
        end
    endtask

    // Transmitter responder: a frame occupies frame_len clocks after DV, then Done pulses.
    int frame_len = 20;
    int tx_cnt    = 0;
    int t_txdone  = 0;
    bit tx_busy   = 1'b0;
    bit tx_hold   = 1'b0;
    bit force_act = 1'b0;
    assign i_TX_Active = tx_busy | force_act;

    always @(posedge i_Clock) begin
        #1;
        if (i_Rst) begin
            tx_cnt    = 0;
            tx_busy   = 1'b0;
            i_TX_Done = 1'b0;
        end else begin
            i_TX_Done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    i_TX_Done = 1'b1;
                    tx_busy   = 1'b0;
                    t_txdone  = tb_cyc;
                end
            end else if (o_TX_DV === 1'b1 && !tx_hold) begin
                tx_cnt  = frame_len;
                tx_busy = 1'b1;
            end
        end
    end

    // Reference model in terms of edge times: a frame is open from grant to Done,
    // and arbitration is allowed again only from edge m_ok_edge onward.
    int         m_cyc, m_owner, m_ptr, m_ok_edge, m_start;
    bit         m_in_frame;
    logic [3:0] e_ack, e_done;
    logic       e_dv, e_to, e_busy;
    logic [7:0] e_byte;
    logic [1:0] e_grant;

    always @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            m_cyc = 0; m_owner = 0; m_ptr = 0; m_ok_edge = 0; m_start = 0;
            m_in_frame = 1'b0;
            e_ack = '0; e_done = '0; e_dv = 1'b0; e_to = 1'b0; e_busy = 1'b0;
            e_byte = '0; e_grant = '0;
        end else begin
            m_cyc++;
            e_ack = '0; e_done = '0; e_dv = 1'b0; e_to = 1'b0;
            if (m_in_frame) begin
                if (i_TX_Done || (TMO_EN && (m_cyc - m_start == TMO))) begin
                    e_to             = !i_TX_Done;
                    e_done[m_owner]  = 1'b1;
                    m_in_frame       = 1'b0;
                    m_ok_edge        = m_cyc + GAP + 1;
                end
            end else if (m_cyc >= m_ok_edge && !i_TX_Active && i_Req_DV != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NREQ;
                    if (!m_in_frame && i_Req_DV[c]) begin
                        m_in_frame = 1'b1;
                        m_owner    = c;
                        m_start    = m_cyc;
                        m_ptr      = (c + 1) % NREQ;
                        e_ack[c]   = 1'b1;
                        e_dv       = 1'b1;
                        e_byte     = i_Req_Byte[c*8 +: 8];
                        e_grant    = 2'(c);
                    end
                end
            end
            e_busy = m_in_frame || (m_cyc < m_ok_edge - 1);
        end
    end

    // Every clock, away from the active edge, compare all outputs against the model.
    always @(negedge i_Clock) begin
        chk("ack",     o_Req_Ack,  e_ack);
        chk("done",    o_Req_Done, e_done);
        chk("tx_dv",   o_TX_DV,    e_dv);
        chk("tx_byte", o_TX_Byte,  e_byte);
        chk("grant",   o_Grant,    e_grant);
        chk("busy",    o_Busy,     e_busy);
        chk("timeout", o_Timeout,  e_to);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    // which: 0 = TX_DV, 1 = any Req_Done, 2 = Timeout
    task automatic wait_for(input int which, input int lim, output int t);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < lim) begin
            case (which)
                0:       hit = (o_TX_DV === 1'b1);
                1:       hit = ((|o_Req_Done) === 1'b1);
                default: hit = (o_Timeout === 1'b1);
            endcase
            if (!hit) begin
                tick(1);
                n++;
            end
        end
        if (!hit) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_%0d: event not seen within %0d cycles", which, lim);
        end
        t = tb_cyc;
    endtask

    int         t_dv, t_done, t_to;
    int         fair_order[6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0] byte_tab[4]   = '{8'h11, 8'h22, 8'hA5, 8'h44};

    initial begin
        #2 i_Rst = 1'b1;
        tick(3);
        chk("rst_busy",  o_Busy,    0);
        chk("rst_dv",    o_TX_DV,   0);
        chk("rst_grant", o_Grant,   0);
        chk("rst_ack",   o_Req_Ack, 0);
        i_Rst = 1'b0;
        tick(2);

        // Single request from requester 2 with a full-length 8N1 frame.
        frame_len = 10 * 217;
        i_Req_DV  = 4'b0100;
        tick(1);
        t_dv = tb_cyc;
        chk("s1_ack",   o_Req_Ack, 4'b0100);
        chk("s1_dv",    o_TX_DV,   1);
        chk("s1_byte",  o_TX_Byte, 8'hA5);
        chk("s1_grant", o_Grant,   2);
        i_Req_DV = '0;
        tick(1);
        chk("s1_dv_one_cycle", o_TX_DV, 0);
        wait_for(1, 2300, t_done);
        chk("s1_done",       o_Req_Done,      4'b0100);
        chk("s1_done_lat",   t_done - t_txdone, 1);
        chk("s1_frame_time", t_done - t_dv,   2171);

        // Transmitter busy: pending requests wait; a withdrawn request is not served.
        frame_len = 20;
        force_act = 1'b1;
        i_Req_DV  = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("act_no_ack", o_Req_Ack, 0);
        end
        i_Req_DV = 4'b0010;
        tick(1);
        chk("act_still_blocked", o_TX_DV, 0);
        force_act = 1'b0;
        tick(1);
        chk("act_ack",   o_Req_Ack, 4'b0010);
        chk("act_grant", o_Grant,   1);
        chk("act_byte",  o_TX_Byte, 8'h22);
        i_Req_DV = '0;
        wait_for(1, 100, t_done);
        tick(8);

        // Reset while waiting for Done: frame dropped silently, requester 3 served afterwards.
        tx_hold  = 1'b1;
        i_Req_DV = 4'b0100;
        tick(1);
        chk("rw_dv", o_TX_DV, 1);
        i_Req_DV = '0;
        tick(5);
        i_Rst = 1'b1;
        #1;
        chk("rw_busy",  o_Busy,    0);
        chk("rw_grant", o_Grant,   0);
        chk("rw_byte",  o_TX_Byte, 0);
        tick(2);
        i_Rst   = 1'b0;
        tx_hold = 1'b0;
        tick(2);
        i_Req_DV = 4'b1000;
        tick(1);
        chk("rw_ack3",   o_Req_Ack, 4'b1000);
        chk("rw_grant3", o_Grant,   3);
        chk("rw_byte3",  o_TX_Byte, 8'h44);
        i_Req_DV = '0;
        wait_for(1, 100, t_done);

        // All requesters asserting: rotation 0,1,2,3,0,1 with the gap honoured after each Done.
        i_Req_DV = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_for(0, 100, t_dv);
            chk("fair_grant", o_Grant,   fair_order[k]);
            chk("fair_byte",  o_TX_Byte, byte_tab[fair_order[k]]);
            chk("fair_gap",   t_dv - t_done, GAP + 1);
            if (k == 5) i_Req_DV = '0;
            tick(1);
            wait_for(1, 100, t_done);
            chk("fair_done", o_Req_Done, 4'b0001 << fair_order[k]);
        end
        tick(8);

        // Transmitter never finishes.
        tx_hold  = 1'b1;
        i_Req_DV = 4'b0001;
        tick(1);
        t_dv = tb_cyc;
        chk("wd_ack", o_Req_Ack, 4'b0001);
        i_Req_DV = '0;
`ifdef UART_ARB_TIMEOUT_EN
        wait_for(2, 200, t_to);
        chk("wd_time", t_to - t_dv, TMO);
        chk("wd_done", o_Req_Done,  4'b0001);
        tick(GAP + 1);
        chk("wd_idle", o_Busy, 0);
`else
        tick(300);
        chk("wd_still_busy", o_Busy,     1);
        chk("wd_no_done",    o_Req_Done, 0);
`endif
        tx_hold = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish (errors=%0d)", n_err);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one 8N1 UART transmitter (the existing TX block, start/data/stop bits, one-cycle DV strobe, one-cycle Done pulse) between NUM_REQ byte producers. It accepts a held byte request, issues a single DV strobe to the transmitter, and waits for its Done pulse. It then reports completion to the winning requester and enforces an optional inter-frame idle gap before the next grant. It sits between the command/telemetry sources and the TX block in the UART subsystem.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
GAP_CLKS, 0, idle clocks inserted after each Done before next grant (0 = none)
TIMEOUT_CLKS, 4096, watchdog limit in WAIT_DONE; used only with UART_ARB_TIMEOUT_EN

Ports:
i_Clock  in  1  system clock
i_Rst  in  1  asynchronous reset, active-high
i_Req_DV  in  NUM_REQ  per-requester request; held high until matching ack
i_Req_Byte  in  8*NUM_REQ  byte of requester k at [8k+7:8k]
o_Req_Ack  out  NUM_REQ  one-cycle pulse: byte of requester k accepted
o_Req_Done  out  NUM_REQ  one-cycle pulse: requester k's frame fully sent
o_TX_DV  out  1  one-cycle strobe to transmitter
o_TX_Byte  out  8  byte to transmitter, stable from DV until Done
i_TX_Active  in  1  transmitter busy flag
i_TX_Done  in  1  transmitter stop-bit-complete pulse
o_Grant  out  IDXW  index of current/last owner, IDXW = max(1,$clog2(NUM_REQ))
o_Busy  out  1  high in any state other than IDLE
o_Timeout  out  1  one-cycle pulse on watchdog abort (0 when feature disabled)

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; rr pointer 0; gap/watchdog counters 0. Reset mid-frame drops the in-flight request silently (no Done reported).
- States: IDLE, WAIT_DONE, GAP.
- IDLE: if any i_Req_DV and i_TX_Active==0, pick first set bit searching from pointer upward with wrap. At the next edge: o_Req_Ack[g]=1, o_TX_DV=1, o_TX_Byte=byte g, o_Grant=g, pointer=(g+1) mod NUM_REQ, state WAIT_DONE. Latency request-to-DV: 1 clock. If i_TX_Active==1, no grant.
- WAIT_DONE: o_TX_DV and o_Req_Ack clear after exactly one cycle. On i_TX_Done: o_Req_Done[g]=1 next cycle; go to GAP if GAP_CLKS>0, else IDLE. Requests arriving meanwhile are pending, not acked.
- GAP: count GAP_CLKS clocks, then go to IDLE. Arbitration resumes in IDLE, so the next DV comes at least GAP_CLKS+1 clocks after the Done pulse.
- i_TX_Done seen in IDLE or GAP: ignored.
- Requester dropping i_Req_DV before ack: withdrawn. Arbitration uses only the current-cycle value.
- Pointer wrap: NUM_REQ-1 advances to 0. Non-power-of-two NUM_REQ must never produce an index >= NUM_REQ.
- Done and a new request in the same cycle: the new request is granted only after GAP/IDLE; no back-to-back DV within WAIT_DONE.
- Fairness: with all requesters always asserting, grants cycle 0,1,..,NUM_REQ-1,0.

Optional Feature:
UART_ARB_TIMEOUT_EN: a watchdog counts clocks in WAIT_DONE. When it reaches TIMEOUT_CLKS without i_TX_Done:
- o_Timeout pulses one cycle
- o_Req_Done[g] pulses (completion is reported even though the frame failed)
- state goes to GAP/IDLE as for a normal Done
The counter clears on entering WAIT_DONE.
Without the macro: no counter; o_Timeout is tied 0; WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum (IDLE, WAIT_DONE, GAP)
  - IDXW computation
  - a byte-width constant of 8
- Sub-module uart_rr_pick: combinational rotate-priority picker with inputs req vector and pointer, outputs valid and index.

Test Plan:
- Single request: i_Req_DV[2]=1, byte 0xA5 -> Ack[2] and TX_DV the next clock with TX_Byte=0xA5, Grant=2. Model TX Done after 10*217 clks -> Done[2] one cycle later.
- All 4 requesting continuously, GAP_CLKS=0 -> grant order 0,1,2,3,0,1, one DV per Done, no DV while Busy.
- GAP_CLKS=5: Done pulse at cycle T -> next TX_DV no earlier than T+6.
- i_TX_Active=1 while requests are pending -> no Ack/DV until Active falls; the grant then follows 1 clock later.
- Reset asserted in WAIT_DONE, then released -> all outputs 0 and pointer 0; the next request from requester 3 is acked normally.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CLKS=100, withhold Done -> o_Timeout and Done[g] pulse 100 clocks after DV, and the arbiter returns to IDLE.
